// File: rtl/mdu_e.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with HI/LO ownership.
// Results are computed at the start edge and committed to HI/LO when the down-counter hits 1.
//
// state  | meaning
// S_IDLE | no operation in flight; start accepted
// S_BUSY | counting down to commit of res_hi/res_lo

module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;
  logic          accept, is_mul, is_div, done;

  logic          sgn, a_neg, b_neg;
  logic [63:0]   a_ext, b_ext, prod;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign accept = (state == S_IDLE) && start;
  assign is_mul = (op == 3'd0) || (op == 3'd1);
  assign is_div = (op == 3'd2) || (op == 3'd3);
  assign done   = (state == S_BUSY) && (count == CW'(1));

  // Even ops (mult/div) are the signed variants.
  assign sgn   = ~op[0];
  assign a_ext = (sgn && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
  assign b_ext = (sgn && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
  assign prod  = a_ext * b_ext;

  // Sign-magnitude divide keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
  assign a_neg = sgn && a[31];
  assign b_neg = sgn && b[31];
  assign a_mag = a_neg ? (32'h0 - a) : a;
  assign b_mag = b_neg ? (32'h0 - b) : b;
  assign q_mag = (b_mag == 32'h0) ? 32'h0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'h0) ? 32'h0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'h0 - r_mag) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (is_mul || is_div)) state_nxt = S_BUSY;
      S_BUSY:  if (count == CW'(1))              state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      res_hi <= 32'h0;
      res_lo <= 32'h0;
      res_wr <= 1'b0;
      hi     <= 32'h0;
      lo     <= 32'h0;
    end else if (accept) begin
      case (op)
        3'd0, 3'd1: begin
          count  <= CW'(MULT_CYCLES);
          res_hi <= prod[63:32];
          res_lo <= prod[31:0];
          res_wr <= 1'b1;
        end
        3'd2, 3'd3: begin
          count  <= CW'(DIV_CYCLES);
          res_hi <= rem;
          res_lo <= quot;
          res_wr <= (b != 32'h0);
        end
        3'd4:    hi <= a;
        3'd5:    lo <= a;
        default: ;
      endcase
    end else if (state == S_BUSY) begin
      count <= count - CW'(1);
      if (done) begin
        res_wr <= 1'b0;
        if (res_wr) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: expected HI/LO pushed to a scoreboard at start, popped at completion.
module tb_mdu_e;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [31:0] cur_hi, cur_lo;

  mdu_e #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div op; optionally scramble operands or inject an mthi while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                        input int cycles, input bit scramble, input int inject);
    int   n;
    exp_t e;
    sb.push_back({eh, el});
    start = 1'b1; op = o; a = av; b = bv;
    tick;
    start = 1'b0;
    if (scramble) begin a = 32'h0; b = 32'h0; end
    n = 0;
    while (busy && n < 40) begin
      n++;
      check({tag, " hold hi"}, hi, cur_hi);
      check({tag, " hold lo"}, lo, cur_lo);
      if (n == inject) begin start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF; end
      tick;
      start = 1'b0;
    end
    check({tag, " busy cycles"}, 32'(n), 32'(cycles));
    e = sb.pop_front();
    check({tag, " hi"}, hi, e.hi);
    check({tag, " lo"}, lo, e.lo);
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] av);
    exp_t e;
    sb.push_back((o == 3'd4) ? {av, cur_lo} : {cur_hi, av});
    start = 1'b1; op = o; a = av;
    tick;
    start = 1'b0;
    e = sb.pop_front();
    check({tag, " busy"}, {31'h0, busy}, 32'h0);
    check({tag, " hi"}, hi, e.hi);
    check({tag, " lo"}, lo, e.lo);
    cur_hi = e.hi;
    cur_lo = e.lo;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'h0; b = 32'h0;
    cur_hi = 32'h0; cur_lo = 32'h0;
    repeat (3) tick;
    reset = 1'b0;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);

    run_op("mult",   3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_CYCLES, 1'b0, 0);
    run_op("multu",  3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MULT_CYCLES, 1'b1, 0);
    run_op("div",    3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYCLES, 1'b0, 0);
    run_op("divu0",  3'd3, 32'd7, 32'd0, cur_hi, cur_lo, DIV_CYCLES, 1'b0, 0);
    run_op("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_CYCLES, 1'b1, 0);
    run_op("divu",   3'd3, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, DIV_CYCLES, 1'b0, 0);

    mt_op("mthi", 3'd4, 32'h1234_5678);
    mt_op("mtlo", 3'd5, 32'h9ABC_DEF0);

    start = 1'b1; op = 3'd6; a = 32'h5555_5555; b = 32'h1;
    tick;
    start = 1'b0;
    check("rsvd busy", {31'h0, busy}, 32'h0);
    check("rsvd hi", hi, cur_hi);
    check("rsvd lo", lo, cur_lo);

    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_CYCLES, 1'b0, 2);

    // Reset in busy cycle 3 discards the in-flight mult.
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    tick;
    start = 1'b0;
    check("rst busy1", {31'h0, busy}, 32'h1);
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    cur_hi = 32'h0; cur_lo = 32'h0;
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick;
      check("postrst busy", {31'h0, busy}, 32'h0);
      check("postrst hi", hi, 32'h0);
      check("postrst lo", lo, 32'h0);
    end

    run_op("b2b mult", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, MULT_CYCLES, 1'b0, 0);
    run_op("b2b div",  3'd2, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYCLES, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
